// File: rtl/dmem_pkg.sv
// Shared definitions for the dual-port data memory controller.
//   - dmem_state_e : controller state (array clear sweep, normal operation)
//   - BYTES_PER_WORD / WORD_LSB : byte-address to word-index mapping
//   - addr_is_bad() : range/alignment predicate for port A byte addresses
package dmem_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dmem_state_e;

    // Port A addresses are byte addresses over 32-bit words.
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_LSB       = 2;

    // A port A byte address is unusable when it is not word aligned, when
    // bits above the word index are set, or when the word index lies past
    // the end of the array (DEPTH need not be a power of two).
    function automatic logic addr_is_bad(
        input logic [31:0] addr,
        input int unsigned idx_w,
        input int unsigned depth
    );
        logic misaligned;
        logic high_bits;
        logic past_end;
        misaligned = (addr[1:0] != 2'b00);
        high_bits  = ((addr >> (idx_w + WORD_LSB)) != 32'd0);
        past_end   = ((addr >> WORD_LSB) >= depth);
        return misaligned || high_bits || past_end;
    endfunction

endpackage

// File: rtl/dmem_dp_ram.sv
// Single-clock true dual-port RAM, inferred.
//   Port A : read/write, per-byte write enables. The read register only
//            loads on read cycles, so a write leaves the last read data.
//   Port B : read only.
// Both ports are read-first with a 1-cycle registered output. The array and
// the output registers carry no reset.
//   clk_i                      clock
//   a_en_i/a_we_i/a_addr_i     port A enable, write select, word index
//   a_be_i/a_wdata_i           port A byte enables and write data
//   a_rdata_o                  port A registered read data
//   b_en_i/b_addr_i            port B enable and word index
//   b_rdata_o                  port B registered read data
module dmem_dp_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 70000,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  a_en_i,
    input  logic                  a_we_i,
    input  logic [IDX_W-1:0]      a_addr_i,
    input  logic [DATA_W/8-1:0]   a_be_i,
    input  logic [DATA_W-1:0]     a_wdata_i,
    output logic [DATA_W-1:0]     a_rdata_o,
    input  logic                  b_en_i,
    input  logic [IDX_W-1:0]      b_addr_i,
    output logic [DATA_W-1:0]     b_rdata_o
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // Port A: byte-masked write, or read into the output register.
    always_ff @(posedge clk_i) begin
        if (a_en_i) begin
            if (a_we_i) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (a_be_i[i]) begin
                        mem_q[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
                    end
                end
            end else begin
                a_rdata_q <= mem_q[a_addr_i];
            end
        end
    end

    // Port B: read-first, so a same-cycle port A write is not visible yet.
    always_ff @(posedge clk_i) begin
        if (b_en_i) begin
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/dmem_dp_ctrl.sv
// Dual-port data memory controller.
// After reset an optional sweep writes zero to every word through RAM port A;
// both ports become ready only once the sweep is done.
//   clk_i, rst_i                clock, asynchronous active-high reset
//   a_req_i/a_we_i/a_addr_i     port A request, write select, byte address
//   a_wdata_i/a_be_i            port A store data and byte enables
//   a_ready_o/a_ack_o           port A ready and 1-cycle completion pulse
//   a_rdata_o/a_err_o           port A read data and error qualifier
//   b_req_i/b_addr_i            port B read request and word index
//   b_ready_o/b_rvalid_o        port B ready and 1-cycle data-valid pulse
//   b_rdata_o/b_err_o           port B read data and error qualifier
//   init_done_o                 high once in normal operation
//   err_count_o                 saturating count of a_err/b_err pulses
module dmem_dp_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 70000,
    parameter int IDX_W      = $clog2(DEPTH),
    parameter int INIT_CLEAR = 1,
    parameter int ERR_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_req_i,
    input  logic                  a_we_i,
    input  logic [31:0]           a_addr_i,
    input  logic [DATA_W-1:0]     a_wdata_i,
    input  logic [DATA_W/8-1:0]   a_be_i,
    output logic                  a_ready_o,
    output logic                  a_ack_o,
    output logic [DATA_W-1:0]     a_rdata_o,
    output logic                  a_err_o,
    input  logic                  b_req_i,
    input  logic [IDX_W-1:0]      b_addr_i,
    output logic                  b_ready_o,
    output logic                  b_rvalid_o,
    output logic [DATA_W-1:0]     b_rdata_o,
    output logic                  b_err_o,
    output logic                  init_done_o,
    output logic [ERR_W-1:0]      err_count_o
);

    localparam int BE_W = DATA_W / 8;

    dmem_state_e          state_q;
    logic [IDX_W-1:0]     init_idx_q;

    logic                 run_s;
    logic                 a_acc_s;
    logic                 a_bad_s;
    logic [IDX_W-1:0]     a_idx_s;
    logic                 b_acc_s;
    logic                 b_bad_s;

    logic                 ram_a_en_s;
    logic                 ram_a_we_s;
    logic [IDX_W-1:0]     ram_a_addr_s;
    logic [BE_W-1:0]      ram_a_be_s;
    logic [DATA_W-1:0]    ram_a_wdata_s;
    logic [DATA_W-1:0]    ram_a_rdata_s;
    logic                 ram_b_en_s;
    logic [IDX_W-1:0]     ram_b_addr_s;
    logic [DATA_W-1:0]    ram_b_rdata_s;

    logic                 a_ack_q,    a_ack_d;
    logic                 a_err_q,    a_err_d;
    logic                 a_zero_q,   a_zero_d;
    logic                 b_rvalid_q, b_rvalid_d;
    logic                 b_err_q,    b_err_d;
    logic                 b_zero_q,   b_zero_d;
    logic [ERR_W-1:0]     err_cnt_q,  err_cnt_d;
    logic [1:0]           err_inc_s;
    logic [ERR_W:0]       err_sum_s;

    assign run_s   = (state_q == ST_RUN);
    assign a_acc_s = a_req_i && run_s;
    assign a_bad_s = addr_is_bad(a_addr_i, IDX_W, DEPTH);
    assign a_idx_s = a_addr_i[IDX_W+WORD_LSB-1:WORD_LSB];
    assign b_acc_s = b_req_i && run_s;
    assign b_bad_s = (32'(b_addr_i) >= 32'(DEPTH));

    // State machine and clear-sweep index: one word cleared per cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
            init_idx_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_idx_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                    end else begin
                        init_idx_q <= init_idx_q + IDX_W'(1);
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q    <= ST_INIT;
                    init_idx_q <= '0;
                end
            endcase
        end
    end

    // RAM port A steering: clear sweep, then CPU accesses. Bad requests
    // are pointed at word 0 with the write suppressed so the array is
    // never indexed out of range.
    always_comb begin
        ram_a_en_s    = 1'b0;
        ram_a_we_s    = 1'b0;
        ram_a_addr_s  = '0;
        ram_a_be_s    = '0;
        ram_a_wdata_s = '0;
        if (!run_s) begin
            ram_a_en_s    = 1'b1;
            ram_a_we_s    = 1'b1;
            ram_a_addr_s  = init_idx_q;
            ram_a_be_s    = {BE_W{1'b1}};
            ram_a_wdata_s = {DATA_W{1'b0}};
        end else if (a_acc_s) begin
            ram_a_en_s    = 1'b1;
            ram_a_we_s    = a_we_i && !a_bad_s;
            ram_a_addr_s  = a_bad_s ? {IDX_W{1'b0}} : a_idx_s;
            ram_a_be_s    = a_be_i;
            ram_a_wdata_s = a_wdata_i;
        end else begin
            ram_a_en_s    = 1'b0;
        end
    end

    // RAM port B steering, with the same out-of-range guard.
    always_comb begin
        ram_b_en_s   = b_acc_s;
        ram_b_addr_s = b_bad_s ? {IDX_W{1'b0}} : b_addr_i;
    end

    dmem_dp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk_i     (clk_i),
        .a_en_i    (ram_a_en_s),
        .a_we_i    (ram_a_we_s),
        .a_addr_i  (ram_a_addr_s),
        .a_be_i    (ram_a_be_s),
        .a_wdata_i (ram_a_wdata_s),
        .a_rdata_o (ram_a_rdata_s),
        .b_en_i    (ram_b_en_s),
        .b_addr_i  (ram_b_addr_s),
        .b_rdata_o (ram_b_rdata_s)
    );

    // Response pipeline next state. The zero flags decide whether the
    // visible read data is the RAM register or forced zero; they only
    // change on events that change the visible data, so a_rdata/b_rdata
    // hold between accesses (a good write leaves a_rdata untouched).
    always_comb begin
        a_ack_d    = a_acc_s;
        a_err_d    = a_acc_s && a_bad_s;
        b_rvalid_d = b_acc_s;
        b_err_d    = b_acc_s && b_bad_s;

        if (a_acc_s && a_bad_s) begin
            a_zero_d = 1'b1;
        end else if (a_acc_s && !a_we_i) begin
            a_zero_d = 1'b0;
        end else begin
            a_zero_d = a_zero_q;
        end

        if (b_acc_s) begin
            b_zero_d = b_bad_s;
        end else begin
            b_zero_d = b_zero_q;
        end

        // Both error pulses in one cycle count as two; clamp at all-ones.
        err_inc_s = {1'b0, a_err_q} + {1'b0, b_err_q};
        err_sum_s = {1'b0, err_cnt_q} + {{(ERR_W-1){1'b0}}, err_inc_s};
        if (err_sum_s[ERR_W]) begin
            err_cnt_d = {ERR_W{1'b1}};
        end else begin
            err_cnt_d = err_sum_s[ERR_W-1:0];
        end
    end

    // Response pipeline registers; reset drops any in-flight response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_ack_q    <= 1'b0;
            a_err_q    <= 1'b0;
            a_zero_q   <= 1'b1;
            b_rvalid_q <= 1'b0;
            b_err_q    <= 1'b0;
            b_zero_q   <= 1'b1;
            err_cnt_q  <= '0;
        end else begin
            a_ack_q    <= a_ack_d;
            a_err_q    <= a_err_d;
            a_zero_q   <= a_zero_d;
            b_rvalid_q <= b_rvalid_d;
            b_err_q    <= b_err_d;
            b_zero_q   <= b_zero_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign a_ready_o   = run_s;
    assign b_ready_o   = run_s;
    assign init_done_o = run_s;
    assign a_ack_o     = a_ack_q;
    assign a_err_o     = a_err_q;
    assign a_rdata_o   = a_zero_q ? {DATA_W{1'b0}} : ram_a_rdata_s;
    assign b_rvalid_o  = b_rvalid_q;
    assign b_err_o     = b_err_q;
    assign b_rdata_o   = b_zero_q ? {DATA_W{1'b0}} : ram_b_rdata_s;
    assign err_count_o = err_cnt_q;

endmodule
